// File: rtl/dmem_port_arbiter_if.sv
// Signal bundle between the data-memory arbiter, its host/CPU requesters and the BRAM port.
// The arbiter takes the slave view; the master view drives requests and the BRAM read data.
interface dmem_port_arbiter_if #(
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic              axi_data_we;
  logic [11:0]       axi_data_addr;
  logic [31:0]       axi_data_wdata;
  logic [3:0]        axi_data_wstrb;
  logic              axi_rd_req;
  logic [11:0]       axi_rd_addr;
  logic              axi_rd_valid;
  logic [31:0]       axi_rd_data;

  logic              cpu_req;
  logic              cpu_we;
  logic [11:0]       cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [3:0]        cpu_wstrb;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [31:0]       cpu_rdata;

  logic              mem_en;
  logic [3:0]        mem_we;
  logic [11:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  logic              err_overflow;
  logic              err_clr;
  logic [LVL_W-1:0]  fifo_level;

  modport slave (
    input  axi_data_we, axi_data_addr, axi_data_wdata, axi_data_wstrb,
    input  axi_rd_req, axi_rd_addr,
    output axi_rd_valid, axi_rd_data,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_wstrb,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output err_overflow, fifo_level,
    input  err_clr
  );

  modport master (
    output axi_data_we, axi_data_addr, axi_data_wdata, axi_data_wstrb,
    output axi_rd_req, axi_rd_addr,
    input  axi_rd_valid, axi_rd_data,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_wstrb,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  err_overflow, fifo_level,
    output err_clr
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port data BRAM between the CPU load/store unit and buffered host traffic.
// CPU has priority; a starvation counter forces one host slot after STARVE_LIMIT lost slots.
module dmem_port_arbiter #(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  dmem_port_arbiter_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } wr_entry_t;

  typedef enum logic [1:0] {TAG_NONE, TAG_CPU, TAG_HOST} tag_e;
  typedef enum logic [1:0] {SLOT_IDLE, SLOT_CPU, SLOT_HWR, SLOT_HRD} slot_e;

  wr_entry_t         fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  level;
  logic              rd_pend;
  logic [11:0]       rd_pend_addr;
  logic [CNT_W-1:0]  starve_cnt;
  tag_e              tag;
  logic [31:0]       cpu_rdata_q;
  logic [31:0]       axi_rd_data_q;
  logic              err_q;

  slot_e             slot_c;
  wr_entry_t         head_c;
  logic              fifo_empty_c;
  logic              fifo_full_c;
  logic              force_c;
  logic              host_wait_c;
  logic              push_c;
  logic              pop_c;
  logic              ovf_c;
  logic              cpu_rv_c;
  logic              host_rv_c;

  // Slot decision: forced host work, then CPU, then host writes before host reads.
  always_comb begin
    fifo_empty_c = (level == '0);
    fifo_full_c  = (level == LVL_W'(FIFO_DEPTH));
    force_c      = (starve_cnt >= CNT_W'(STARVE_LIMIT));
    host_wait_c  = !fifo_empty_c || rd_pend;
    head_c       = fifo_mem[rd_ptr];
    slot_c       = SLOT_IDLE;
    if (rst)                           slot_c = SLOT_IDLE;
    else if (force_c && !fifo_empty_c) slot_c = SLOT_HWR;
    else if (force_c && rd_pend)       slot_c = SLOT_HRD;
    else if (bus.cpu_req)              slot_c = SLOT_CPU;
    else if (!fifo_empty_c)            slot_c = SLOT_HWR;
    else if (rd_pend)                  slot_c = SLOT_HRD;
    pop_c  = (slot_c == SLOT_HWR);
    push_c = !rst && bus.axi_data_we && (!fifo_full_c || pop_c);
    ovf_c  = bus.axi_data_we && fifo_full_c && !pop_c;
  end

  // BRAM port and CPU grant follow the slot decision in the same cycle.
  always_comb begin
    bus.cpu_gnt   = 1'b0;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 4'h0;
    bus.mem_addr  = 12'h000;
    bus.mem_wdata = 32'h0;
    case (slot_c)
      SLOT_CPU: begin
        bus.cpu_gnt   = 1'b1;
        bus.mem_en    = 1'b1;
        bus.mem_we    = bus.cpu_we ? bus.cpu_wstrb : 4'h0;
        bus.mem_addr  = bus.cpu_addr;
        bus.mem_wdata = bus.cpu_we ? bus.cpu_wdata : 32'h0;
      end
      SLOT_HWR: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = head_c.wstrb;
        bus.mem_addr  = head_c.addr;
        bus.mem_wdata = head_c.wdata;
      end
      SLOT_HRD: begin
        bus.mem_en    = 1'b1;
        bus.mem_addr  = rd_pend_addr;
      end
      default: ;
    endcase
  end

  // Return path: BRAM data arrives the cycle after issue, steered by the issue tag.
  always_comb begin
    cpu_rv_c         = !rst && (tag == TAG_CPU);
    host_rv_c        = !rst && (tag == TAG_HOST);
    bus.cpu_rvalid   = cpu_rv_c;
    bus.axi_rd_valid = host_rv_c;
    bus.cpu_rdata    = rst ? 32'h0 : (cpu_rv_c  ? bus.mem_rdata : cpu_rdata_q);
    bus.axi_rd_data  = rst ? 32'h0 : (host_rv_c ? bus.mem_rdata : axi_rd_data_q);
    bus.err_overflow = err_q;
    bus.fifo_level   = level;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level         <= '0;
      rd_pend       <= 1'b0;
      rd_pend_addr  <= 12'h000;
      starve_cnt    <= '0;
      tag           <= TAG_NONE;
      cpu_rdata_q   <= 32'h0;
      axi_rd_data_q <= 32'h0;
      err_q         <= 1'b0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_c && !pop_c)      level <= level + LVL_W'(1);
      else if (pop_c && !push_c) level <= level - LVL_W'(1);

      // A new request overwrites the pending one; a same-cycle issue used the old address.
      if (bus.axi_rd_req) begin
        rd_pend      <= 1'b1;
        rd_pend_addr <= bus.axi_rd_addr;
      end else if (slot_c == SLOT_HRD) begin
        rd_pend      <= 1'b0;
      end

      if (host_wait_c && (slot_c == SLOT_CPU)) begin
        if (!force_c) starve_cnt <= starve_cnt + CNT_W'(1);
      end else begin
        starve_cnt <= '0;
      end

      case (slot_c)
        SLOT_CPU: tag <= bus.cpu_we ? TAG_NONE : TAG_CPU;
        SLOT_HRD: tag <= TAG_HOST;
        default:  tag <= TAG_NONE;
      endcase

      if (cpu_rv_c)  cpu_rdata_q   <= bus.mem_rdata;
      if (host_rv_c) axi_rd_data_q <= bus.mem_rdata;

      if (bus.err_clr) err_q <= 1'b0;
      else if (ovf_c)  err_q <= 1'b1;
    end
  end

  // Entry storage needs no reset; occupancy is tracked by level and the pointers.
  always_ff @(posedge clk) begin
    if (push_c) fifo_mem[wr_ptr] <= '{addr: bus.axi_data_addr, wdata: bus.axi_data_wdata,
                                      wstrb: bus.axi_data_wstrb};
  end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: queue-based reference of the arbitration rules with a
// response scoreboard, a behavioural BRAM, directed scenarios and a randomized phase.
module tb_dmem_port_arbiter;
  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_port_arbiter_if #(.FIFO_DEPTH(DEPTH)) bus ();
  dmem_port_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct { logic [11:0] addr; logic [31:0] data; logic [3:0] strb; } wr_t;
  typedef struct { int due; logic [31:0] data; } rsp_t;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  bit          gnt_seen = 1'b0;
  logic [31:0] bram    [4096];
  logic [31:0] ref_mem [4096];
  wr_t         m_fifo [$];
  rsp_t        cpu_q  [$];
  rsp_t        host_q [$];
  bit          m_rd_pend = 1'b0;
  logic [11:0] m_rd_addr = 12'h000;
  int          m_starve  = 0;
  bit          m_err     = 1'b0;
  logic [31:0] last_axi  = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural single-port BRAM with one-cycle read latency.
  always @(posedge clk) begin
    if (bus.mem_en === 1'b1) begin
      bus.mem_rdata <= bram[bus.mem_addr];
      bram[bus.mem_addr] <= merge(bram[bus.mem_addr], bus.mem_wdata, bus.mem_we);
    end
  end

  // Reference model: evaluates the slot rules from queue state, checks the port, predicts responses.
  always @(negedge clk) begin : model
    int          slot;
    bit          has_wr;
    bit          frc;
    bit          ovf;
    bit          e_en;
    bit          e_gnt;
    logic [3:0]  e_we;
    logic [11:0] e_addr;
    logic [31:0] e_wd;
    rsp_t        rs;
    wr_t         w;
    if (rst) begin
      chk("rst_cpu_gnt", 32'(bus.cpu_gnt), 32'h0);
      chk("rst_mem_en",  32'(bus.mem_en),  32'h0);
      chk("rst_mem_we",  32'(bus.mem_we),  32'h0);
      m_fifo.delete();
      cpu_q.delete();
      host_q.delete();
      m_rd_pend = 1'b0;
      m_starve  = 0;
      m_err     = 1'b0;
      gnt_seen  = 1'b0;
    end else begin
      chk("fifo_level",   32'(bus.fifo_level),   32'(m_fifo.size()));
      chk("err_overflow", 32'(bus.err_overflow), 32'(m_err));
      has_wr = (m_fifo.size() != 0);
      frc    = (m_starve >= LIMIT);
      if (frc && has_wr)         slot = 2;
      else if (frc && m_rd_pend) slot = 3;
      else if (bus.cpu_req)      slot = 1;
      else if (has_wr)           slot = 2;
      else if (m_rd_pend)        slot = 3;
      else                       slot = 0;
      e_en = (slot != 0); e_gnt = (slot == 1);
      e_we = 4'h0; e_addr = 12'h000; e_wd = 32'h0;
      if (slot == 1) begin
        e_addr = bus.cpu_addr;
        if (bus.cpu_we) begin e_we = bus.cpu_wstrb; e_wd = bus.cpu_wdata; end
      end else if (slot == 2) begin
        e_addr = m_fifo[0].addr; e_we = m_fifo[0].strb; e_wd = m_fifo[0].data;
      end else if (slot == 3) begin
        e_addr = m_rd_addr;
      end
      chk("cpu_gnt",   32'(bus.cpu_gnt),   32'(e_gnt));
      chk("mem_en",    32'(bus.mem_en),    32'(e_en));
      chk("mem_we",    32'(bus.mem_we),    32'(e_we));
      chk("mem_addr",  32'(bus.mem_addr),  32'(e_addr));
      chk("mem_wdata", bus.mem_wdata, e_wd);
      gnt_seen = (bus.cpu_gnt === 1'b1);

      rs.due = cyc + 1;
      rs.data = ref_mem[e_addr];
      if (slot == 1 && !bus.cpu_we) cpu_q.push_back(rs);
      if (slot == 3) host_q.push_back(rs);
      if (slot == 1 || slot == 2) ref_mem[e_addr] = merge(ref_mem[e_addr], e_wd, e_we);

      if ((has_wr || m_rd_pend) && slot == 1) m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
      else m_starve = 0;

      ovf = 1'b0;
      if (slot == 2) m_fifo.delete(0);
      if (bus.axi_data_we) begin
        if (m_fifo.size() < DEPTH) begin
          w.addr = bus.axi_data_addr; w.data = bus.axi_data_wdata; w.strb = bus.axi_data_wstrb;
          m_fifo.push_back(w);
        end else begin
          ovf = 1'b1;
        end
      end
      if (bus.err_clr) m_err = 1'b0;
      else if (ovf)    m_err = 1'b1;
      if (slot == 3) m_rd_pend = 1'b0;
      if (bus.axi_rd_req) begin m_rd_pend = 1'b1; m_rd_addr = bus.axi_rd_addr; end
    end
  end

  // Response monitor: pops the predicted read data whenever the DUT presents a valid.
  always @(negedge clk) begin : monitor
    rsp_t r;
    if (rst) begin
      chk("rst_cpu_rvalid",   32'(bus.cpu_rvalid),   32'h0);
      chk("rst_axi_rd_valid", 32'(bus.axi_rd_valid), 32'h0);
      last_axi = 32'h0;
    end else begin
      if (bus.cpu_rvalid === 1'b1) begin
        if (cpu_q.size() == 0) chk("cpu_rvalid_unexpected", 32'(bus.cpu_rvalid), 32'h0);
        else begin
          r = cpu_q.pop_front();
          chk("cpu_rdata", bus.cpu_rdata, r.data);
          chk("cpu_rvalid_cycle", 32'(cyc), 32'(r.due));
        end
      end else if (cpu_q.size() != 0 && cpu_q[0].due <= cyc) begin
        chk("cpu_rvalid_missing", 32'(bus.cpu_rvalid), 32'h1);
        void'(cpu_q.pop_front());
      end

      if (bus.axi_rd_valid === 1'b1) begin
        if (host_q.size() == 0) chk("axi_rd_valid_unexpected", 32'(bus.axi_rd_valid), 32'h0);
        else begin
          r = host_q.pop_front();
          chk("axi_rd_data", bus.axi_rd_data, r.data);
          chk("axi_rd_valid_cycle", 32'(cyc), 32'(r.due));
          last_axi = r.data;
        end
      end else begin
        if (host_q.size() != 0 && host_q[0].due <= cyc) begin
          chk("axi_rd_valid_missing", 32'(bus.axi_rd_valid), 32'h1);
          void'(host_q.pop_front());
        end
        chk("axi_rd_data_hold", bus.axi_rd_data, last_axi);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    bus.axi_data_we = 1'b0;
    bus.axi_rd_req  = 1'b0;
    bus.err_clr     = 1'b0;
  endtask

  task automatic hwrite(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    bus.axi_data_we = 1'b1; bus.axi_data_addr = a; bus.axi_data_wdata = d; bus.axi_data_wstrb = s;
  endtask

  task automatic cpu_set(input logic req, input logic we, input logic [11:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d; bus.cpu_wstrb = s;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      bram[i]    = 32'hA500_0000 ^ (32'(i) * 32'h0001_0101);
      ref_mem[i] = 32'hA500_0000 ^ (32'(i) * 32'h0001_0101);
    end
    bus.axi_data_we = 1'b0; bus.axi_data_addr = 12'h000; bus.axi_data_wdata = 32'h0;
    bus.axi_data_wstrb = 4'h0; bus.axi_rd_req = 1'b0; bus.axi_rd_addr = 12'h000;
    bus.err_clr = 1'b0;
    cpu_set(1'b0, 1'b0, 12'h000, 32'h0, 4'h0);
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();

    // Idle CPU: host write then read back.
    hwrite(12'h010, 32'hDEADBEEF, 4'hF);
    step();
    bus.axi_rd_req = 1'b1; bus.axi_rd_addr = 12'h010;
    repeat (5) step();

    // Continuous CPU reads starve one host write until the forced slot.
    cpu_set(1'b1, 1'b0, 12'h000, 32'h0, 4'h0);
    step();
    hwrite(12'h030, 32'hCAFEF00D, 4'hF);
    repeat (14) step();

    // Overflow under CPU pressure, push during a forced pop while full, and err_clr priority.
    for (int i = 0; i < 14; i++) begin
      hwrite(12'h100 + 12'(i), $urandom, 4'hF);
      if (i == 6) bus.err_clr = 1'b1;
      step();
    end
    cpu_set(1'b0, 1'b0, 12'h000, 32'h0, 4'h0);
    bus.err_clr = 1'b1;
    repeat (8) step();
    for (int i = 0; i < 4; i++) begin
      bus.axi_rd_req = 1'b1; bus.axi_rd_addr = 12'h100 + 12'(i * 3);
      repeat (3) step();
    end

    // Read-after-write through the FIFO while the CPU is busy.
    cpu_set(1'b1, 1'b1, 12'h040, 32'h5555_AAAA, 4'h3);
    hwrite(12'h020, 32'h11111111, 4'hF);
    step();
    bus.axi_rd_req = 1'b1; bus.axi_rd_addr = 12'h020;
    repeat (30) step();
    cpu_set(1'b0, 1'b0, 12'h000, 32'h0, 4'h0);
    repeat (5) step();

    // Reset lands the cycle after a granted CPU read.
    cpu_set(1'b1, 1'b0, 12'h005, 32'h0, 4'h0);
    step();
    cpu_set(1'b0, 1'b0, 12'h000, 32'h0, 4'h0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (3) step();

    // Randomized traffic with varying CPU load.
    for (int k = 0; k < 4000; k++) begin
      int pct;
      pct = (k < 1500) ? 85 : ((k < 2800) ? 40 : 97);
      if (!bus.cpu_req || gnt_seen) begin
        if ($urandom_range(0, 99) < pct)
          cpu_set(1'b1, 1'($urandom_range(0, 1)), 12'($urandom_range(0, 15)), $urandom,
                  4'($urandom_range(0, 15)));
        else
          cpu_set(1'b0, 1'b0, 12'h000, 32'h0, 4'h0);
      end
      if ($urandom_range(0, 99) < 30)
        hwrite(12'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 99) < 12) begin
        bus.axi_rd_req = 1'b1; bus.axi_rd_addr = 12'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 99) < 3) bus.err_clr = 1'b1;
      rst = ($urandom_range(0, 799) == 0);
      step();
    end
    rst = 1'b0;
    cpu_set(1'b0, 1'b0, 12'h000, 32'h0, 4'h0);
    repeat (40) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Arbitrates the single-port data-memory BRAM between the CPU load/store unit and the host-side AXI-Lite write/read path. Sits directly downstream of the CPU AXI-Lite interface: consumes its one-cycle `axi_data_we`/`axi_data_addr`/`axi_data_wdata`/`axi_data_wstrb` write pulses, buffers them in a small FIFO, and returns host read data. Gives the CPU priority, with a starvation guard so host accesses always make progress.

## Interface
- `FIFO_DEPTH`, 4: host write buffer entries (power of two, ≥2).
- `STARVE_LIMIT`, 8: consecutive lost arbitration slots before the host path is forced through.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `axi_data_we` in 1: host write pulse, one cycle per write.
- `axi_data_addr` in 12: host write word address.
- `axi_data_wdata` in 32: host write data.
- `axi_data_wstrb` in 4: host byte strobes.
- `axi_rd_req` in 1: host read request pulse.
- `axi_rd_addr` in 12: host read word address, sampled with `axi_rd_req`.
- `axi_rd_valid` out 1: one-cycle pulse; `axi_rd_data` valid.
- `axi_rd_data` out 32: host read data, held until next `axi_rd_valid`.
- `cpu_req` in 1: CPU access request, held until granted.
- `cpu_we` in 1: CPU write (1) / read (0).
- `cpu_addr` in 12: CPU word address.
- `cpu_wdata` in 32 / `cpu_wstrb` in 4: CPU store data and strobes.
- `cpu_gnt` out 1: combinational; CPU access issued this cycle.
- `cpu_rvalid` out 1: CPU read data valid (one cycle after granted read).
- `cpu_rdata` out 32: CPU read data.
- `mem_en` out 1 / `mem_we` out 4 / `mem_addr` out 12 / `mem_wdata` out 32: BRAM port, combinational from the arbitration decision.
- `mem_rdata` in 32: BRAM read data, one-cycle latency.
- `err_overflow` out 1: sticky; host write dropped because the FIFO was full.
- `err_clr` in 1: clears `err_overflow`.
- `fifo_level` out log2(FIFO_DEPTH)+1: current FIFO occupancy.

## Operation
- Host write FIFO: push on `axi_data_we`. Push while full with no pop in the same cycle drops the write and sets `err_overflow`. Push and pop in the same cycle while full are both accepted; level stays the same.
- Read-pending register: one entry, loaded on `axi_rd_req`. A second `axi_rd_req` while pending overwrites the address; only one response is returned. Reads issue only when the FIFO is empty, which preserves read-after-write ordering for host traffic.
- `force` = starve counter ≥ `STARVE_LIMIT`.
- Per-cycle slot decision, first match wins:
  - `force` and FIFO non-empty → FIFO head write.
  - `force` and read pending → host read.
  - `cpu_req` → CPU access.
  - FIFO non-empty → FIFO head write.
  - Read pending → host read.
  - Otherwise idle: `mem_en`=0.
- Starve counter: increments when host work is waiting (FIFO non-empty or read pending) and the CPU takes the slot. Clears when a host access issues or no host work is waiting. Saturates at `STARVE_LIMIT`.
- Issue encoding:
  - `mem_en`=1 for any access.
  - `mem_we` = strobes on a write, 4'b0000 on a read.
  - A CPU write with `cpu_wstrb`=0 still issues and is granted.
- Return path: a 2-bit tag registered at issue (none/CPU/host) steers `mem_rdata` on the next cycle. A CPU read produces `cpu_rvalid`; a host read loads `axi_rd_data` and pulses `axi_rd_valid`.
- `err_clr` has priority over a same-cycle overflow: the flag ends cleared.

## Timing
- Reset values: `cpu_gnt`=0, `cpu_rvalid`=0, `cpu_rdata`=0, `axi_rd_valid`=0, `axi_rd_data`=0, `mem_en`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `err_overflow`=0, `fifo_level`=0. FIFO, read-pending register, tag and counter are all cleared.
- Reset mid-operation discards buffered writes, any pending read and any in-flight return; no `*_rvalid` pulse follows reset.
- Host write latency (idle CPU): `axi_data_we` at cycle N → `mem_en`/`mem_we` at N+1.
- Host read latency (empty FIFO, idle CPU): `axi_rd_req` at N → issue at N+1 → `axi_rd_valid` at N+2.
- CPU latency: grant is same-cycle when uncontested; read data at grant+1.
- Worst-case host wait under continuous `cpu_req`: `STARVE_LIMIT` lost slots, then one forced slot.
- FIFO pointers wrap modulo `FIFO_DEPTH`. `fifo_level` is registered and reflects pushes and pops from the previous cycle.

## Test plan
- Idle CPU; host writes 0xDEADBEEF, strobes 4'hF, to address 0x010; read back 0x010 → `mem_we`=4'hF one cycle after the pulse; `axi_rd_valid` 2 cycles after the request with 0xDEADBEEF.
- `cpu_req` held high with reads to 0x000; one host write queued → CPU granted 8 cycles; cycle 9 `cpu_gnt`=0 and the host write issues; CPU resumes at cycle 10.
- Five host writes back-to-back under continuous `cpu_req` (no drain) → fifth dropped, `err_overflow`=1, `fifo_level`=4; `err_clr` → flag 0.
- FIFO full; push and forced pop in the same cycle → no overflow, `fifo_level` stays 4, data order preserved across pointer wrap.
- Host write 0x11111111 to 0x020, then `axi_rd_req` to 0x020 one cycle later while the CPU is busy → read returns 0x11111111, never the old contents.
- `rst` asserted the cycle after a granted CPU read → no `cpu_rvalid`; all outputs at reset values the next cycle.
